// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 holding SR, Cause, EPC and PrID; raises IntReq for traps
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2020_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1_i,
    input  logic [4:0]  a2_i,
    input  logic [31:0] din_i,
    input  logic        we_i,
    input  logic [29:0] pc_i,
    input  logic        if_bd_i,
    input  logic [4:0]  exc_code_i,
    input  logic [5:0]  hw_int_i,
    input  logic        exl_clr_i,
    output logic        int_req_o,
    output logic [29:0] epc_o,
    output logic [31:0] dout_o
);
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [29:0] epc_q, epc_d;
    logic        int_p, exc_p;
    logic        wr_sr, wr_epc;
    logic [31:0] sr, cause;

    assign int_p     = (|(hw_int_i & im_q)) & ie_q & ~exl_q;
    assign exc_p     = (exc_code_i != 5'd0) & ~exl_q;
    assign int_req_o = int_p | exc_p;
    assign epc_o     = epc_q;
    assign sr        = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause     = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
    // A mtc0 only lands when neither a trap nor an eret claims this edge
    assign wr_sr     = we_i & ~int_req_o & ~exl_clr_i & (a2_i == 5'd12);
    assign wr_epc    = we_i & ~int_req_o & ~exl_clr_i & (a2_i == 5'd14);

    // Next-state selection: trap entry, then eret, then mtc0
    always_comb begin
        im_d  = wr_sr ? din_i[15:10] : im_q;
        ie_d  = wr_sr ? din_i[0] : ie_q;
        exl_d = int_req_o ? 1'b1 : exl_clr_i ? 1'b0 : wr_sr ? din_i[1] : exl_q;
        exc_d = int_req_o ? (int_p ? 5'd0 : exc_code_i) : exc_q;
        bd_d  = int_req_o ? if_bd_i : bd_q;
        epc_d = int_req_o ? (if_bd_i ? pc_i - 30'd1 : pc_i) : wr_epc ? din_i[31:2] : epc_q;
    end

    // Register update; pending interrupt lines are sampled every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= hw_int_i;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // mfc0 read mux from registered state only
    always_comb begin
        dout_o = (a1_i == 5'd12) ? sr :
                 (a1_i == 5'd13) ? cause :
                 (a1_i == 5'd14) ? {epc_q, 2'b00} :
                 (a1_i == 5'd15) ? PRID : 32'h0;
    end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed vectors for cp0_unit with hand-computed expectations
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2, exc_code;
    logic [31:0] din;
    logic        we, if_bd, exl_clr;
    logic [29:0] pc;
    logic [5:0]  hw_int;
    logic        int_req;
    logic [29:0] epc;
    logic [31:0] dout;
    int          vectors = 0;
    int          miscompares = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .a1_i(a1), .a2_i(a2), .din_i(din), .we_i(we),
        .pc_i(pc), .if_bd_i(if_bd), .exc_code_i(exc_code), .hw_int_i(hw_int),
        .exl_clr_i(exl_clr), .int_req_o(int_req), .epc_o(epc), .dout_o(dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        a1 = addr;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1; a2 = addr; din = data;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; a1 = 5'd0; a2 = 5'd0; din = '0; we = 1'b0; pc = '0;
        if_bd = 1'b0; exc_code = '0; hw_int = '0; exl_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h2020_0001);
        check("rst_intreq", {31'b0, int_req}, 32'h0);

        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc = 30'h0C00_0C05; if_bd = 1'b0;
        #1;
        check("int_req_hw", {31'b0, int_req}, 32'h1);
        tick();
        rd("int_epc", 5'd14, 32'h3000_3014);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        check("int_exl_mask", {31'b0, int_req}, 32'h0);

        hw_int = 6'b0;
        mtc0(5'd12, 32'h0000_0400);
        check("no_req_ie0", {31'b0, int_req}, 32'h0);
        exc_code = 5'd4; if_bd = 1'b1;
        #1;
        check("exc_req", {31'b0, int_req}, 32'h1);
        tick();
        exc_code = 5'd0; if_bd = 1'b0;
        rd("exc_epc_bd", 5'd14, 32'h3000_3010);
        rd("exc_cause_bd", 5'd13, 32'h8000_0010);

        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code = 5'd10; pc = 30'h0000_0100;
        #1;
        check("both_req", {31'b0, int_req}, 32'h1);
        tick();
        exc_code = 5'd0;
        rd("both_cause", 5'd13, 32'h0000_0400);
        check("both_epc", {2'b0, epc}, 32'h0000_0100);

        #1;
        check("exl_masks_hw", {31'b0, int_req}, 32'h0);
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        #1;
        check("eret_reopens", {31'b0, int_req}, 32'h1);
        rd("eret_sr", 5'd12, 32'h0000_0401);

        pc = 30'h0000_0200;
        mtc0(5'd14, 32'hDEAD_BEE0);
        rd("trap_beats_mtc0", 5'd14, 32'h0000_0800);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0400);
        rd("other_addr", 5'd3, 32'h0);

        hw_int = 6'b0;
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0003; exl_clr = 1'b1;
        tick();
        we = 1'b0; exl_clr = 1'b0;
        rd("eret_beats_mtc0", 5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h0000_1234);
        check("epc_write", {2'b0, epc}, 32'h0000_048D);

        hw_int = 6'b000001; reset = 1'b1;
        #1;
        check("pre_reset_req", {31'b0, int_req}, 32'h1);
        tick();
        reset = 1'b0; hw_int = 6'b0;
        rd("reset_wins_sr", 5'd12, 32'h0);
        rd("reset_wins_epc", 5'd14, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
